// File: rtl/rtype_exec_ctrl_pkg.sv
// Shared definitions for the R-type execute sequencer: opcodes, funct7 codes,
// FSM state encoding, ALU class codes and the decoded-instruction record.
package rtype_exec_ctrl_pkg;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned ALU_CTRL_W = 6;

  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    ALU_CLS_OP   = 2'b00,
    ALU_CLS_OP32 = 2'b01
  } alu_cls_e;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    READ,
    EXEC,
    WB
  } state_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic                  is_op32;
    logic                  illegal;
  } dec_t;

  // OP-32 results are the low word sign-extended to the full datapath.
  function automatic logic [XLEN-1:0] sext_word(input logic [XLEN-1:0] v);
    return {{(XLEN-32){v[31]}}, v[31:0]};
  endfunction

endpackage

// File: rtl/rtype_exec_ctrl_if.sv
// Bus between the R-type sequencer and its environment (fetch, reg_file, ALU).
// master = sequencer side, slave = environment side.
interface rtype_exec_ctrl_if;
  import rtype_exec_ctrl_pkg::*;

  logic                  instr_valid;
  logic                  instr_ready;
  logic [31:0]           instr;
  logic [REG_ADDR_W-1:0] rf_rs1;
  logic [REG_ADDR_W-1:0] rf_rs2;
  logic [XLEN-1:0]       rf_rdata1;
  logic [XLEN-1:0]       rf_rdata2;
  logic [XLEN-1:0]       alu_a;
  logic [XLEN-1:0]       alu_b;
  logic [ALU_CTRL_W-1:0] alu_ctrl;
  logic [XLEN-1:0]       alu_result;
  logic                  rf_wr_en;
  logic [REG_ADDR_W-1:0] rf_wr_addr;
  logic [XLEN-1:0]       rf_wr_data;
  logic                  done;
  logic                  illegal;

  modport master (
    input  instr_valid, instr, rf_rdata1, rf_rdata2, alu_result,
    output instr_ready, rf_rs1, rf_rs2, alu_a, alu_b, alu_ctrl,
           rf_wr_en, rf_wr_addr, rf_wr_data, done, illegal
  );

  modport slave (
    output instr_valid, instr, rf_rdata1, rf_rdata2, alu_result,
    input  instr_ready, rf_rs1, rf_rs2, alu_a, alu_b, alu_ctrl,
           rf_wr_en, rf_wr_addr, rf_wr_data, done, illegal
  );

endinterface

// File: rtl/rtype_exec_ctrl_decode.sv
// Combinational R-type decoder: instruction word -> register indices,
// ALU control, OP-32 flag and legality.
module rtype_exec_ctrl_decode
  import rtype_exec_ctrl_pkg::*;
(
  input  logic [31:0] instr_i,
  output dec_t        dec_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       bad_opc;
  logic       bad_f7;
  logic       bad_alt;
  alu_cls_e   cls;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  assign bad_opc = (opcode != OPC_OP) && (opcode != OPC_OP32);
  assign bad_f7  = (funct7 != FUNCT7_BASE) && (funct7 != FUNCT7_ALT);
  // The alternate funct7 only encodes SUB and SRA.
  assign bad_alt = (funct7 == FUNCT7_ALT) && (funct3 != 3'b000) && (funct3 != 3'b101);
  assign cls     = (opcode == OPC_OP32) ? ALU_CLS_OP32 : ALU_CLS_OP;

  always_comb begin
    dec_o          = '0;
    dec_o.rs1      = instr_i[19:15];
    dec_o.rs2      = instr_i[24:20];
    dec_o.rd       = instr_i[11:7];
    dec_o.alu_ctrl = {cls, instr_i[30], funct3};
    dec_o.is_op32  = (opcode == OPC_OP32);
    dec_o.illegal  = bad_opc || bad_f7 || bad_alt;
  end

endmodule

// File: rtl/rtype_exec_ctrl.sv
// Multi-cycle R-type sequencer: accept, decode, read operands, capture ALU
// result, single write-back. All outputs are registered.
module rtype_exec_ctrl
  import rtype_exec_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  rtype_exec_ctrl_if.master bus
);

  state_e                state_q;
  dec_t                  dec;
  logic                  ready_q;
  logic [REG_ADDR_W-1:0] rs1_q;
  logic [REG_ADDR_W-1:0] rs2_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [ALU_CTRL_W-1:0] alu_ctrl_q;
  logic                  op32_q;
  logic [XLEN-1:0]       alu_a_q;
  logic [XLEN-1:0]       alu_b_q;
  logic                  wr_en_q;
  logic [REG_ADDR_W-1:0] wr_addr_q;
  logic [XLEN-1:0]       wr_data_q;
  logic                  done_q;
  logic                  illegal_q;

  rtype_exec_ctrl_decode u_decode (
    .instr_i (bus.instr),
    .dec_o   (dec)
  );

  // Decoding happens on the accept edge so the DECODE-state outputs
  // (addresses, ALU control, illegal pulse) are already registered in cycle 1.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      ready_q    <= 1'b1;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      alu_ctrl_q <= '0;
      op32_q     <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      wr_en_q   <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.instr_valid && ready_q) begin
            ready_q    <= 1'b0;
            rs1_q      <= dec.rs1;
            rs2_q      <= dec.rs2;
            rd_q       <= dec.rd;
            alu_ctrl_q <= dec.alu_ctrl;
            op32_q     <= dec.is_op32;
            illegal_q  <= dec.illegal;
            state_q    <= DECODE;
          end
        end
        DECODE: begin
          if (illegal_q) begin
            ready_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            state_q <= READ;
          end
        end
        READ: begin
          alu_a_q <= bus.rf_rdata1;
          alu_b_q <= bus.rf_rdata2;
          state_q <= EXEC;
        end
        EXEC: begin
          wr_data_q <= op32_q ? sext_word(bus.alu_result) : bus.alu_result;
          wr_addr_q <= rd_q;
          wr_en_q   <= (rd_q != '0);
          done_q    <= 1'b1;
          state_q   <= WB;
        end
        WB: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.instr_ready = ready_q;
  assign bus.rf_rs1      = rs1_q;
  assign bus.rf_rs2      = rs2_q;
  assign bus.alu_ctrl    = alu_ctrl_q;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.rf_wr_en    = wr_en_q;
  assign bus.rf_wr_addr  = wr_addr_q;
  assign bus.rf_wr_data  = wr_data_q;
  assign bus.done        = done_q;
  assign bus.illegal     = illegal_q;

endmodule

// File: tb/tb_rtype_exec_ctrl.sv
// Scoreboard bench for rtype_exec_ctrl: directed instructions push expected
// retire/reject records; a negedge monitor pops and compares on done/illegal.
module tb_rtype_exec_ctrl;
  import rtype_exec_ctrl_pkg::*;

  typedef struct {
    logic        ill;
    logic        wr_en;
    logic [4:0]  addr;
    logic [63:0] data;
    logic [5:0]  ctrl;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] a;
    logic [63:0] b;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   last_acc = 0;
  int   acc_q[$];
  exp_t sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rtype_exec_ctrl_if bus ();

  rtype_exec_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic ill, input logic wr_en, input logic [4:0] addr,
                              input logic [63:0] data, input logic [5:0] ctrl,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    e.ill = ill; e.wr_en = wr_en; e.addr = addr; e.data = data; e.ctrl = ctrl;
    e.rs1 = rs1; e.rs2 = rs2; e.a = a; e.b = b;
    return e;
  endfunction

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (bus.instr_valid === 1'b1 && bus.instr_ready === 1'b1) begin
      last_acc = cyc;
      acc_q.push_back(cyc);
    end
    if (bus.illegal === 1'b1)
      chk("illegal_exclusive", 64'(bus.done | bus.rf_wr_en), 64'd0);
    if (bus.rf_wr_en === 1'b1)
      chk("wr_en_with_done", 64'(bus.done), 64'd1);
    if (bus.done === 1'b1 || bus.illegal === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event actual done=%0b illegal=%0b required none", bus.done, bus.illegal);
      end else begin
        e = sbq.pop_front();
        chk("illegal", 64'(bus.illegal), 64'(e.ill));
        chk("latency", 64'(cyc - last_acc), e.ill ? 64'd1 : 64'd4);
        chk("wr_en", 64'(bus.rf_wr_en), 64'(e.wr_en));
        if (!e.ill) begin
          chk("wr_addr", 64'(bus.rf_wr_addr), 64'(e.addr));
          chk("wr_data", bus.rf_wr_data, e.data);
          chk("alu_ctrl", 64'(bus.alu_ctrl), 64'(e.ctrl));
          chk("rs1", 64'(bus.rf_rs1), 64'(e.rs1));
          chk("rs2", 64'(bus.rf_rs2), 64'(e.rs2));
          chk("alu_a", bus.alu_a, e.a);
          chk("alu_b", bus.alu_b, e.b);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (bus.instr_ready !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual ready=%0b required 1", name, bus.instr_ready);
    end
  endtask

  // Offer one instruction with its environment data; wait until it is finished.
  task automatic issue(input logic [31:0] ins, input logic [63:0] r1, input logic [63:0] r2,
                       input logic [63:0] res, input exp_t e);
    step();
    bus.instr      = ins;
    bus.rf_rdata1  = r1;
    bus.rf_rdata2  = r2;
    bus.alu_result = res;
    bus.instr_valid = 1'b1;
    wait_ready("accept");
    sbq.push_back(e);
    step();
    bus.instr_valid = 1'b0;
    wait_ready("retire");
  endtask

  initial begin
    int s;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.rf_rdata1   = '0;
    bus.rf_rdata2   = '0;
    bus.alu_result  = '0;
    repeat (3) step();
    chk("rst_ready", 64'(bus.instr_ready), 64'd1);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_illegal", 64'(bus.illegal), 64'd0);
    chk("rst_wr_en", 64'(bus.rf_wr_en), 64'd0);
    chk("rst_wr_data", bus.rf_wr_data, 64'd0);
    chk("rst_alu_a", bus.alu_a, 64'd0);
    chk("rst_alu_ctrl", 64'(bus.alu_ctrl), 64'd0);
    chk("rst_rs1", 64'(bus.rf_rs1), 64'd0);
    reset = 1'b1;

    // ADD x3,x1,x2
    issue(32'h002081B3, 64'd5, 64'd7, 64'd12,
          mk(1'b0, 1'b1, 5'd3, 64'd12, 6'b000000, 5'd1, 5'd2, 64'd5, 64'd7));
    // SUB x3,x1,x2
    issue(32'h402081B3, 64'd20, 64'd7, 64'd13,
          mk(1'b0, 1'b1, 5'd3, 64'd13, 6'b001000, 5'd1, 5'd2, 64'd20, 64'd7));
    // ADDW: low word sign-extended
    issue(32'h002081BB, 64'h7FFF_FFFF, 64'd1, 64'h0000_0000_8000_0000,
          mk(1'b0, 1'b1, 5'd3, 64'hFFFF_FFFF_8000_0000, 6'b010000, 5'd1, 5'd2,
             64'h7FFF_FFFF, 64'd1));
    // SUBW: upper garbage dropped, positive word
    issue(32'h402081BB, 64'h11, 64'h22, 64'hDEAD_BEEF_7FFF_FFFF,
          mk(1'b0, 1'b1, 5'd3, 64'h0000_0000_7FFF_FFFF, 6'b011000, 5'd1, 5'd2,
             64'h11, 64'h22));
    // SRA (alt funct7, funct3=101): full 64-bit result passes through
    issue(32'h4020D1B3, 64'hF0, 64'd4, 64'hF000_0000_0000_0001,
          mk(1'b0, 1'b1, 5'd3, 64'hF000_0000_0000_0001, 6'b001101, 5'd1, 5'd2,
             64'hF0, 64'd4));
    // OR x10,x11,x12
    issue(32'h00C5E533, 64'hA5A5, 64'h5A5A, 64'hFFFF,
          mk(1'b0, 1'b1, 5'd10, 64'hFFFF, 6'b000110, 5'd11, 5'd12, 64'hA5A5, 64'h5A5A));
    // ADD x0,x1,x2: retires without a write
    issue(32'h00208033, 64'd4, 64'd5, 64'd9,
          mk(1'b0, 1'b0, 5'd0, 64'd9, 6'b000000, 5'd1, 5'd2, 64'd4, 64'd5));
    // Illegal: OP-IMM opcode, funct7=0000001, alt funct7 with funct3=001
    issue(32'h00208193, 64'd1, 64'd1, 64'd1, mk(1'b1, 1'b0, '0, '0, '0, '0, '0, '0, '0));
    issue(32'h022081B3, 64'd1, 64'd1, 64'd1, mk(1'b1, 1'b0, '0, '0, '0, '0, '0, '0, '0));
    issue(32'h402091B3, 64'd1, 64'd1, 64'd1, mk(1'b1, 1'b0, '0, '0, '0, '0, '0, '0, '0));

    // Reset during EXEC aborts without write or done (no expectation pushed)
    step();
    bus.instr       = 32'h002081B3;
    bus.rf_rdata1   = 64'd3;
    bus.rf_rdata2   = 64'd3;
    bus.alu_result  = 64'd6;
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("abort_ready", 64'(bus.instr_ready), 64'd1);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_wr_en", 64'(bus.rf_wr_en), 64'd0);
    repeat (4) step();
    issue(32'h002081B3, 64'd8, 64'd9, 64'd17,
          mk(1'b0, 1'b1, 5'd3, 64'd17, 6'b000000, 5'd1, 5'd2, 64'd8, 64'd9));

    // instr_valid held for 10 cycles: accepts at offsets 0 and 5
    step();
    acc_q.delete();
    s = cyc;
    bus.instr       = 32'h002081B3;
    bus.rf_rdata1   = 64'd100;
    bus.rf_rdata2   = 64'd1;
    bus.alu_result  = 64'd101;
    bus.instr_valid = 1'b1;
    sbq.push_back(mk(1'b0, 1'b1, 5'd3, 64'd101, 6'b000000, 5'd1, 5'd2, 64'd100, 64'd1));
    sbq.push_back(mk(1'b0, 1'b1, 5'd3, 64'd101, 6'b000000, 5'd1, 5'd2, 64'd100, 64'd1));
    repeat (10) step();
    bus.instr_valid = 1'b0;
    wait_ready("hold_retire");
    chk("hold_accepts", 64'(acc_q.size()), 64'd2);
    if (acc_q.size() == 2) begin
      chk("hold_acc0", 64'(acc_q[0] - s), 64'd0);
      chk("hold_acc1", 64'(acc_q[1] - s), 64'd5);
    end

    repeat (6) step();
    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
